// File: rtl/snake_move_ctrl.sv
// Movement controller for one snake head: turns level buttons into tick-paced
// direction strobes, blocks 180-degree reversals and runs the IDLE/RUN/PAUSE/DEAD game.
module snake_move_ctrl #(
    parameter int         TICK_CYCLES = 12500000,
    parameter logic [1:0] START_DIR   = 2'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        start,
    input  logic        pause,
    input  logic        collision,
    output logic        left,
    output logic        right,
    output logic        up,
    output logic        down,
    output logic        dead,
    output logic        head_reset_n,
    output logic [1:0]  state,
    output logic [1:0]  dir,
    output logic [15:0] step_count
);
    localparam int            CW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DEAD  = 2'b11
    } state_t;

    state_t        state_reg;
    logic [1:0]    dir_reg;
    logic [1:0]    pending_reg;
    logic [CW-1:0] cnt_reg;
    logic [3:0]    strobe_reg;
    logic [3:0]    btn_hist_reg;
    logic          dead_reg;
    logic          head_reset_n_reg;
    logic [15:0]   step_count_reg;

    // Button and strobe vectors are indexed by the direction code (0 up .. 3 left).
    logic [3:0] btn_now;
    logic [3:0] btn_edge;
    logic [1:0] cand;
    logic       cand_valid;

    assign btn_now = {btn_left, btn_down, btn_right, btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_edge
            assign btn_edge[gi] = btn_now[gi] & ~btn_hist_reg[gi];
        end
    endgenerate

    // Reversal check is against the committed direction, not the pending one.
    always_comb begin
        cand = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (btn_edge[i]) cand = 2'(i);
        end
        cand_valid = $onehot(btn_edge) && (cand != (dir_reg ^ 2'd2));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            dir_reg          <= START_DIR;
            pending_reg      <= START_DIR;
            cnt_reg          <= '0;
            strobe_reg       <= 4'b0000;
            btn_hist_reg     <= 4'b0000;
            dead_reg         <= 1'b0;
            head_reset_n_reg <= 1'b0;
            step_count_reg   <= 16'd0;
        end else begin
            btn_hist_reg <= btn_now;
            strobe_reg   <= 4'b0000;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg        <= RUN;
                        cnt_reg          <= '0;
                        step_count_reg   <= 16'd0;
                        dir_reg          <= START_DIR;
                        pending_reg      <= START_DIR;
                        head_reset_n_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (cand_valid) pending_reg <= cand;
                    if (collision) begin
                        state_reg <= DEAD;
                        dead_reg  <= 1'b1;
                    end else if (pause) begin
                        state_reg <= PAUSE;
                    end else if (cnt_reg == CNT_LAST) begin
                        // Step uses the pending value from before this edge.
                        cnt_reg    <= '0;
                        strobe_reg <= 4'b0001 << pending_reg;
                        dir_reg    <= pending_reg;
                        if (step_count_reg != 16'hFFFF)
                            step_count_reg <= step_count_reg + 16'd1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                PAUSE: begin
                    if (pause) state_reg <= RUN;
                end
                DEAD: begin
                    if (start) begin
                        state_reg        <= IDLE;
                        dead_reg         <= 1'b0;
                        head_reset_n_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign up           = strobe_reg[0];
    assign right        = strobe_reg[1];
    assign down         = strobe_reg[2];
    assign left         = strobe_reg[3];
    assign dead         = dead_reg;
    assign head_reset_n = head_reset_n_reg;
    assign state        = state_reg;
    assign dir          = dir_reg;
    assign step_count   = step_count_reg;

endmodule

// File: doc/snake_move_ctrl.md
# snake_move_ctrl

Per-player movement controller that sequences one snake-head block. It turns level button inputs into one-cycle direction step strobes at a fixed game-tick rate. It rejects 180° reversals and runs the IDLE/RUN/PAUSE/DEAD game state. It also drives the head's dead flag and active-low reset, and sits between the input synchronizers, the collision checker and the head block.

## Interface
Parameters:
- TICK_CYCLES, default 12500000: clk cycles per movement step; must be ≥ 2; counter width is $clog2(TICK_CYCLES).
- START_DIR, default 2'd1: direction loaded at reset and on each game start. Encoding: 0 = up, 1 = right, 2 = down, 3 = left.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock; forces all state to reset values.
- btn_left, btn_right, btn_up, btn_down  in  1 each  synchronized level buttons.
- start  in  1  one-cycle pulse; IDLE→RUN, DEAD→IDLE.
- pause  in  1  one-cycle pulse; toggles RUN↔PAUSE.
- collision  in  1  level from the collision checker; meaningful in RUN only.
- left, right, up, down  out  1 each  registered one-cycle step strobes to the head.
- dead  out  1  registered; high in DEAD.
- head_reset_n  out  1  registered active-low head reset; low in IDLE.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DEAD.
- dir  out  2  committed direction (the last one stepped).
- step_count  out  16  steps taken this game; saturates at 16'hFFFF.

## Operation
- Reset values: state = IDLE, dir = pending = START_DIR, tick counter = 0, all strobes = 0, dead = 0, head_reset_n = 0, step_count = 0, button history = 0.
- FSM transitions:
  - IDLE + start → RUN. Clears the counter and step_count; sets dir and pending to START_DIR.
  - RUN + collision → DEAD. Collision has priority over pause and over the tick.
  - RUN + pause → PAUSE.
  - PAUSE + pause → RUN.
  - DEAD + start → IDLE.
  - All other inputs hold the current state. start in RUN or PAUSE is ignored.
- Outputs per state:
  - head_reset_n = 0 in IDLE, 1 otherwise.
  - dead = 1 in DEAD only.
- Button handling:
  - Rising edges are detected against the previous-cycle sample.
  - Edges are processed in RUN only; the history register updates in every state.
  - Exactly one rising edge in a cycle → candidate direction. Two or more simultaneous edges → ignored.
  - A candidate equal to dir ^ 2 (opposite of the committed dir) is rejected. Otherwise it overwrites pending.
  - Several turns within one tick are allowed; the last legal one wins. The reversal check always uses the committed dir, so a quick double turn cannot reverse the snake.
- Tick counter:
  - Advances only in RUN, and only on cycles where no collision and no pause are sampled.
  - On cycles where it advances and it is at TICK_CYCLES-1, it wraps to 0 and the step event occurs:
    - exactly one strobe matching pending is asserted;
    - dir ← pending;
    - step_count increments, saturating at 16'hFFFF.
  - The counter holds its value in PAUSE.
- The strobe uses the pending value from before that edge. A button edge sampled on the same edge takes effect at the next tick.
- No strobe is ever asserted outside RUN. Two strobes are never high together.

## Timing
- All outputs are registered. The FSM and state output change on the edge that samples the controlling input.
- start is sampled at edge E0, so RUN is visible after E0. The first strobe is high for exactly the cycle after edge E0+TICK_CYCLES, and then once every TICK_CYCLES cycles.
- collision sampled at edge E → state = 11 and dead = 1 after E. A strobe that would have fired at E is suppressed.
- pause: the edges that enter and leave PAUSE do not advance the counter. A step is therefore delayed by exactly (cycles paused + 2) relative to uninterrupted RUN.
- Button edge sampled at E → pending updated after E; it is applied at the first tick edge after E.
- Reset mid-game: reset values appear after the reset edge, regardless of state. A strobe that would fire on that edge is suppressed.

## Test plan
All scenarios use TICK_CYCLES = 4 and START_DIR = 1.
- Start and run: reset, then start pulse → state = 01 next cycle. right strobes appear 4, 8 and 12 cycles after the start edge, each exactly 1 cycle wide. step_count reads 1, 2, 3. head_reset_n goes 0→1 when RUN is entered.
- Turn and reversal: while dir = right, press btn_left → rejected, the next strobe is right. Press btn_up then btn_left within one tick → left rejected, the next strobe is up and dir = 0. Press btn_up and btn_down together → ignored.
- Collision: raise collision on the same edge as a tick → no strobe, state = 11, dead = 1, step_count unchanged. Then start → state = 00, dead = 0, head_reset_n = 0.
- Pause: pause sampled when counter = 1, hold 10 cycles, pause again → zero strobes while paused. The next strobe comes on the 3rd edge after the resume edge, and dir is unchanged.
- Reset mid-RUN: assert reset one cycle before a tick → no strobe. All outputs take reset values after the edge (state = 00, dir = 1, step_count = 0).
- Saturation: force many ticks (or preload via hierarchical force to 16'hFFFE) → step_count stops at 16'hFFFF while strobes continue.
